// File: rtl/icache_fetch_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package icache_fetch_pkg;

  typedef enum logic [1:0] {
    LOOKUP  = 2'd0,
    REFILL  = 2'd1,
    INSTALL = 2'd2
  } state_e;

  localparam int DATA_W = 16;

  // Field helpers take the geometry as arguments so the same package serves
  // any LINES/WORDS parameterisation; the caller casts the result to width.
  function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
    return addr & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int idx_w,
                                           input int off_w);
    return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w,
                                           input int off_w);
    return addr >> (idx_w + off_w);
  endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: n/a (wires only).
// Backpressure: stall toward IF; mem_rd_req held until mem_rdata_vld.
// Ports: slave = cache view, master = IF stage + memory + perf monitor view.
interface icache_fetch_if #(
  parameter int AW = 16
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          inv_all;
  logic [15:0]   instr;
  logic          instr_vld;
  logic          stall;
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata;
  logic          mem_rdata_vld;
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;

  modport slave (
    input  fetch_req, fetch_addr, inv_all, mem_rdata, mem_rdata_vld,
    output instr, instr_vld, stall, mem_rd_req, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output fetch_req, fetch_addr, inv_all, mem_rdata, mem_rdata_vld,
    input  instr, instr_vld, stall, mem_rd_req, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_fetch_sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear.
// Latency: count visible the cycle after en.
// Backpressure: none; sticks at 16'hFFFF.
// Ports: clk, clr (sync, 1 = clear), en (count this cycle), cnt (current value).
module sat_cnt16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only I-cache: combinational hit path, line refill on miss.
// Latency: hit same cycle; miss hits WORDS*L+2 cycles later (L = per-beat memory latency).
// Backpressure: stall held from the miss cycle through INSTALL; one memory read outstanding.
// Ports: clk, rst_n (sync, active-high), bus (slave: fetch, inv_all, memory, counters).
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int AW    = 16
) (
  input logic           clk,
  input logic           rst_n,
  icache_fetch_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = AW - IDX_W - OFF_W;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [OFF_W-1:0]   beat_q, beat_d;
  logic [AW-1:0]      miss_base_q, miss_base_d;
  logic               pend_inv_q, pend_inv_d;

  logic [DATA_W-1:0]  data_q [LINES][WORDS];
  logic [TAG_W-1:0]   tag_q  [LINES];

  logic [TAG_W-1:0]   f_tag, miss_tag;
  logic [IDX_W-1:0]   f_idx, miss_idx;
  logic [OFF_W-1:0]   f_off;
  logic               hit, data_we, tag_we, hit_en, miss_en;
  logic [DATA_W-1:0]  instr_o;
  logic               instr_vld_o, stall_o, mem_rd_req_o;
  logic [AW-1:0]      mem_addr_o;

  assign f_tag    = TAG_W'(addr_tag(32'(bus.fetch_addr), IDX_W, OFF_W));
  assign f_idx    = IDX_W'(addr_idx(32'(bus.fetch_addr), IDX_W, OFF_W));
  assign f_off    = OFF_W'(addr_off(32'(bus.fetch_addr), OFF_W));
  assign miss_tag = TAG_W'(addr_tag(32'(miss_base_q), IDX_W, OFF_W));
  assign miss_idx = IDX_W'(addr_idx(32'(miss_base_q), IDX_W, OFF_W));

  // Tag array is never reset; the valid bit gates the compare.
  assign hit = bus.fetch_req && valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  always_comb begin
    state_d       = state_q;
    // inv_all clears valids at the next edge in every state; this cycle's
    // lookup still sees valid_q.
    valid_d       = bus.inv_all ? '0 : valid_q;
    beat_d        = beat_q;
    miss_base_d   = miss_base_q;
    pend_inv_d    = pend_inv_q;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    hit_en        = 1'b0;
    miss_en       = 1'b0;
    instr_o       = '0;
    instr_vld_o   = 1'b0;
    stall_o       = 1'b0;
    mem_rd_req_o  = 1'b0;
    mem_addr_o    = '0;

    case (state_q)
      LOOKUP: begin
        if (hit) begin
          instr_vld_o = 1'b1;
          instr_o     = data_q[f_idx][f_off];
          hit_en      = 1'b1;
        end else if (bus.fetch_req) begin
          stall_o     = 1'b1;
          miss_base_d = {f_tag, f_idx, {OFF_W{1'b0}}};
          beat_d      = '0;
          miss_en     = 1'b1;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        stall_o      = 1'b1;
        mem_rd_req_o = 1'b1;
        mem_addr_o   = miss_base_q + AW'(beat_q);
        // An invalidate mid-refill must also kill the line being fetched.
        pend_inv_d   = pend_inv_q | bus.inv_all;
        if (bus.mem_rdata_vld) begin
          data_we = 1'b1;
          if (beat_q == OFF_W'(WORDS - 1)) state_d = INSTALL;
          else                             beat_d  = beat_q + OFF_W'(1);
        end
      end
      INSTALL: begin
        stall_o           = 1'b1;
        tag_we            = 1'b1;
        valid_d[miss_idx] = ~(pend_inv_q | bus.inv_all);
        pend_inv_d        = 1'b0;
        state_d           = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= LOOKUP;
      valid_q     <= '0;
      beat_q      <= '0;
      miss_base_q <= '0;
      pend_inv_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
      miss_base_q <= miss_base_d;
      pend_inv_q  <= pend_inv_d;
    end
  end

  // Storage arrays carry no reset; writes only happen from REFILL/INSTALL,
  // so a late memory response after reset (state LOOKUP) writes nothing.
  always_ff @(posedge clk) begin
    if (data_we) data_q[miss_idx][beat_q] <= bus.mem_rdata;
    if (tag_we)  tag_q[miss_idx]          <= miss_tag;
  end

  sat_cnt16 u_hit_cnt (
    .clk (clk),
    .clr (rst_n),
    .en  (hit_en),
    .cnt (bus.hit_cnt)
  );

  sat_cnt16 u_miss_cnt (
    .clk (clk),
    .clr (rst_n),
    .en  (miss_en),
    .cnt (bus.miss_cnt)
  );

  assign bus.instr      = instr_o;
  assign bus.instr_vld  = instr_vld_o;
  assign bus.stall      = stall_o;
  assign bus.mem_rd_req = mem_rd_req_o;
  assign bus.mem_addr   = mem_addr_o;
endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a latency-programmable memory responder.
// Latency: memory answers each beat mem_lat cycles after its address appears.
// Backpressure: responder holds off until mem_rd_req; expected traffic tracked in queues.
module tb_icache_fetch;
  import icache_fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   mem_lat  = 2;

  logic        resp_vld, late_vld;
  logic [15:0] resp_dat, late_dat;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];

  icache_fetch_if #(.AW(16)) ifc ();

  icache_fetch #(.LINES(8), .WORDS(4), .AW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  assign ifc.mem_rdata_vld = resp_vld | late_vld;
  assign ifc.mem_rdata     = late_vld ? late_dat : resp_dat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [15:0] a);
    logic [15:0] base;
    base = a - 16'(addr_off(32'(a), 2));
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 16'(i));
  endtask

  // Memory responder: data = addr ^ A5A5; each served beat is popped from the
  // expected-address scoreboard and compared.
  initial begin
    int   age;
    logic prev_req, prev_vld;
    age = 0; prev_req = 1'b0; prev_vld = 1'b0;
    resp_vld = 1'b0; resp_dat = '0;
    forever begin
      tick();
      if (prev_req && !prev_vld) age++;
      else                       age = 0;
      resp_vld = ifc.mem_rd_req && (age == mem_lat - 1);
      resp_dat = ifc.mem_addr ^ 16'hA5A5;
      if (resp_vld) begin
        if (exp_addr_q.size() == 0) chk("mem_addr_unexpected", ifc.mem_addr, 32'hFFFF_FFFF);
        else                        chk("mem_addr_seq", ifc.mem_addr, exp_addr_q.pop_front());
      end
      prev_req = ifc.mem_rd_req;
      prev_vld = resp_vld;
    end
  end

  // Fetch a; optional redirect / inv_all pulse at given cycle; expect the hit
  // exp_lat cycles after the first lookup cycle.
  task automatic fetch_wait(input logic [15:0] a, input int exp_lat, input int redir_cyc,
                            input logic [15:0] redir_a, input int inv_cyc, input string tag);
    int   cyc;
    logic got;
    tick();
    ifc.fetch_req  = 1'b1;
    ifc.fetch_addr = a;
    exp_instr_q.push_back(a ^ 16'hA5A5);
    if (exp_lat > 0) push_line(a);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) chk({tag, "_stall_c0"}, ifc.stall, (exp_lat > 0) ? 1 : 0);
      if (ifc.instr_vld) got = 1'b1;
      else begin
        tick();
        cyc++;
        ifc.inv_all = 1'b0;
        if (cyc == redir_cyc) begin
          ifc.fetch_addr = redir_a;
          void'(exp_instr_q.pop_back());
          exp_instr_q.push_back(redir_a ^ 16'hA5A5);
          push_line(redir_a);
        end
        if (cyc == inv_cyc) begin
          ifc.inv_all = 1'b1;
          push_line(a);
        end
      end
    end
    chk({tag, "_hit_seen"}, got, 1);
    chk({tag, "_latency"}, cyc, exp_lat);
    if (got) chk({tag, "_instr"}, ifc.instr, exp_instr_q.pop_front());
    tick();
    ifc.fetch_req = 1'b0;
    ifc.inv_all   = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b1; late_vld = 1'b0; late_dat = '0;
    ifc.fetch_req = 1'b0; ifc.fetch_addr = '0; ifc.inv_all = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_instr_vld", ifc.instr_vld, 0);
    chk("rst_stall", ifc.stall, 0);
    chk("rst_mem_rd_req", ifc.mem_rd_req, 0);
    chk("rst_mem_addr", ifc.mem_addr, 0);
    chk("rst_hit_cnt", ifc.hit_cnt, 0);
    chk("rst_miss_cnt", ifc.miss_cnt, 0);
    tick();
    rst_n = 1'b0;

    // Cold miss, L=2
    mem_lat = 2;
    fetch_wait(16'h0005, 10, -1, '0, -1, "cold");
    chk("cold_miss_cnt", ifc.miss_cnt, 1);

    // Spatial hits on the freshly installed line
    for (int i = 4; i < 8; i++) begin
      ifc.fetch_req  = 1'b1;
      ifc.fetch_addr = 16'(i);
      @(negedge clk);
      chk("spatial_vld", ifc.instr_vld, 1);
      chk("spatial_stall", ifc.stall, 0);
      chk("spatial_instr", ifc.instr, 16'(i) ^ 16'hA5A5);
      tick();
    end
    ifc.fetch_req = 1'b0;
    @(negedge clk);
    chk("spatial_hit_cnt", ifc.hit_cnt, 5);

    // Conflict eviction on index 0, L=1
    mem_lat = 1;
    fetch_wait(16'h0000, 6, -1, '0, -1, "conf_a");
    fetch_wait(16'h0020, 6, -1, '0, -1, "conf_b");
    fetch_wait(16'h0000, 6, -1, '0, -1, "conf_c");
    chk("conf_miss_cnt", ifc.miss_cnt, 4);

    // inv_all during beat 2: line installs invalid, refetch misses again
    mem_lat = 2;
    fetch_wait(16'h0008, 20, -1, '0, 5, "inv_refill");
    chk("inv_miss_cnt", ifc.miss_cnt, 6);
    fetch_wait(16'h0000, 10, -1, '0, -1, "inv_old_line");

    // Redirect at beat 1: 0x0010 line installs, then 0x0004 misses and refills
    fetch_wait(16'h0010, 20, 3, 16'h0004, -1, "redirect");
    fetch_wait(16'h0010, 0, -1, '0, -1, "redir_installed");

    // inv_all in LOOKUP: same-cycle hit still reported, then miss
    tick();
    ifc.fetch_req = 1'b1; ifc.fetch_addr = 16'h0010; ifc.inv_all = 1'b1;
    @(negedge clk);
    chk("inv_lookup_hit", ifc.instr_vld, 1);
    tick();
    ifc.inv_all = 1'b0; ifc.fetch_req = 1'b0;
    fetch_wait(16'h0010, 10, -1, '0, -1, "inv_lookup_after");
    chk("mid_miss_cnt", ifc.miss_cnt, 10);
    chk("mid_hit_cnt", ifc.hit_cnt, 14);
    chk("mid_addr_q_empty", exp_addr_q.size(), 0);

    // Reset at beat 1 of a refill, then a stray memory response
    tick();
    ifc.fetch_req = 1'b1; ifc.fetch_addr = 16'h0030;
    push_line(16'h0030);
    tick(); tick(); tick();
    rst_n = 1'b1; ifc.fetch_req = 1'b0;
    tick();
    @(negedge clk);
    chk("rstmid_mem_rd_req", ifc.mem_rd_req, 0);
    chk("rstmid_stall", ifc.stall, 0);
    exp_addr_q.delete();
    tick();
    rst_n = 1'b0; late_vld = 1'b1; late_dat = 16'hDEAD;
    tick();
    late_vld = 1'b0;
    @(negedge clk);
    chk("late_mem_rd_req", ifc.mem_rd_req, 0);
    chk("late_stall", ifc.stall, 0);
    chk("late_hit_cnt", ifc.hit_cnt, 0);
    chk("late_miss_cnt", ifc.miss_cnt, 0);
    fetch_wait(16'h0030, 10, -1, '0, -1, "post_rst");

    // Saturation: stream hits up to FFFE, then two more
    ifc.fetch_req = 1'b1; ifc.fetch_addr = 16'h0030;
    n = 0;
    @(negedge clk);
    while (ifc.hit_cnt != 16'hFFFE && n < 70000) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("sat_preset", ifc.hit_cnt, 16'hFFFE);
    tick();
    tick();
    ifc.fetch_req = 1'b0;
    @(negedge clk);
    chk("sat_two_more", ifc.hit_cnt, 16'hFFFF);
    ifc.fetch_req = 1'b1;
    tick(); tick(); tick();
    ifc.fetch_req = 1'b0;
    tick();
    @(negedge clk);
    chk("sat_hold", ifc.hit_cnt, 16'hFFFF);
    chk("sat_miss_cnt", ifc.miss_cnt, 1);
    chk("end_addr_q_empty", exp_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
